// File: rtl/avalon_pwm_pkg.sv
// avalon_pwm_pkg: register map, CTRL bit positions and default widths for avalon_pwm_bank
package avalon_pwm_pkg;
  localparam int NUM_CH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  localparam int PRE_W_DEF = 16;
  localparam logic [3:0] ADDR_CTRL = 4'd0;
  localparam logic [3:0] ADDR_PRESCALE = 4'd1;
  localparam logic [3:0] ADDR_PERIOD = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_COUNT = 4'd4;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'd8;
  localparam int RUN_BIT = 31;
  localparam int IRQ_EN_BIT = 30;
endpackage

// File: rtl/avalon_pwm_bank_if.sv
// avalon_pwm_bank_if: Avalon-MM slave bus (no waitrequest, read latency 1)
interface avalon_pwm_bank_if;
  logic [3:0] avs_address;
  logic avs_read;
  logic avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/avalon_pwm_bank_pwm_timebase.sv
// pwm_timebase: shared prescaler and period counter; wrap_o is high on the tick that returns cnt to 0
module pwm_timebase #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic wrap_o
);
  logic [PRE_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic tick;
  // >= rather than == so a lowered limit wraps on the next tick instead of running away
  assign tick = pre_cnt_q >= prescale_i;
  assign wrap_o = run_i & tick & (cnt_q >= period_i);
  assign cnt_o = cnt_q;
  always_ff @(posedge clk) begin
    if (reset || !run_i) begin
      pre_cnt_q <= '0;
      cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
      cnt_q <= cnt_q >= period_i ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pre_cnt_q <= pre_cnt_q + PRE_W'(1);
    end
  end
endmodule

// File: rtl/avalon_pwm_bank.sv
// avalon_pwm_bank: Avalon-MM PWM bank with double-buffered duty; optional irq via AVALON_PWM_IRQ_EN
module avalon_pwm_bank import avalon_pwm_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic clk,
  input  logic reset,
  avalon_pwm_bank_if.slave bus,
  output logic [NUM_CH-1:0] pwm_out
`ifdef AVALON_PWM_IRQ_EN
  ,
  output logic irq
`endif
);
  logic [7:0] ch_en_q;
  logic run_q;
  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] pend_q [NUM_CH];
  logic [CNT_W-1:0] act_q [NUM_CH];
  logic [31:0] rdata_q, rdata_d, ctrl_rd, duty_rd, status_rd;
  logic [NUM_CH-1:0] pwm_d;
  logic [CNT_W-1:0] cnt;
  logic wrap;
  logic [3:0] addr;
  logic [31:0] wd;
  logic wr;
  logic unused_wd;
  assign addr = bus.avs_address;
  assign wd = bus.avs_writedata;
  assign wr = bus.avs_write;
  assign unused_wd = ^wd;
  assign bus.avs_readdata = rdata_q;
`ifdef AVALON_PWM_IRQ_EN
  logic irq_en_q, flag_q;
  assign status_rd = 32'(flag_q);
`else
  assign status_rd = '0;
`endif
  pwm_timebase #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_timebase (
    .clk(clk), .reset(reset), .run_i(run_q), .prescale_i(pre_q), .period_i(per_q),
    .cnt_o(cnt), .wrap_o(wrap)
  );
  always_comb begin
    ctrl_rd = 32'(ch_en_q);
    ctrl_rd[RUN_BIT] = run_q;
`ifdef AVALON_PWM_IRQ_EN
    ctrl_rd[IRQ_EN_BIT] = irq_en_q;
`endif
    duty_rd = '0;
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = run_q & ch_en_q[i] & (cnt < act_q[i]);
      if (addr == ADDR_DUTY_BASE + 4'(i)) duty_rd = 32'(pend_q[i]);
    end
    rdata_d = addr == ADDR_CTRL     ? ctrl_rd :
              addr == ADDR_PRESCALE ? 32'(pre_q) :
              addr == ADDR_PERIOD   ? 32'(per_q) :
              addr == ADDR_STATUS   ? status_rd :
              addr == ADDR_COUNT    ? 32'(cnt) : duty_rd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_en_q <= '0;
      run_q <= 1'b0;
      pre_q <= '0;
      per_q <= '0;
      rdata_q <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend_q[i] <= '0;
        act_q[i] <= '0;
      end
`ifdef AVALON_PWM_IRQ_EN
      irq_en_q <= 1'b0;
      flag_q <= 1'b0;
      irq <= 1'b0;
`endif
    end else begin
      if (wr && addr == ADDR_CTRL) begin
        ch_en_q <= wd[7:0];
        run_q <= wd[RUN_BIT];
`ifdef AVALON_PWM_IRQ_EN
        irq_en_q <= wd[IRQ_EN_BIT];
`endif
      end
      if (wr && addr == ADDR_PRESCALE) pre_q <= wd[PRE_W-1:0];
      if (wr && addr == ADDR_PERIOD) per_q <= wd[CNT_W-1:0];
      // active duty only moves at a wrap (or freely while stopped), so a wrap sees the old pending value
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && addr == ADDR_DUTY_BASE + 4'(i)) pend_q[i] <= wd[CNT_W-1:0];
        if (!run_q || wrap) act_q[i] <= pend_q[i];
      end
      pwm_out <= pwm_d;
      if (bus.avs_read) rdata_q <= rdata_d;
`ifdef AVALON_PWM_IRQ_EN
      flag_q <= wrap | (flag_q & ~(wr && addr == ADDR_STATUS && wd[0]));
      irq <= flag_q & irq_en_q;
`endif
    end
  end
endmodule
